// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive control - line sync, start detect, LSB-first shift-in,
// stop-bit check, and ready/framing/overrun flags for the APB register block.
module uart_rx_ctrl #(
    parameter int MAX_DATA = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                serial_in,
    input  logic [3:0]          data_size,
    input  logic                shift_strobe,
    input  logic                packet_done,
    input  logic                data_read,
    output logic                enable_timer,
    output logic [MAX_DATA-1:0] rx_data,
    output logic                data_ready,
    output logic                framing_error,
    output logic                overrun_error
);
    localparam logic [3:0] MAX_N = 4'(MAX_DATA);

    typedef enum logic [2:0] {IDLE, RECEIVING, CHECK, LOAD, FERR} state_t;

    state_t              r_state, w_next;
    logic                r_sync1, r_sync2, r_prev;
    logic [MAX_DATA:0]   r_sr;
    logic [MAX_DATA-1:0] r_data;
    logic                r_ready, r_ferr, r_ovr;
    logic                w_start_edge, w_accept;
    logic [3:0]          w_n;
    logic [MAX_DATA-1:0] w_word;

    assign w_start_edge = r_prev & ~r_sync2;
    assign w_accept     = (r_state == IDLE) & w_start_edge;
    // Out-of-range sizes fall back to a full-width frame
    assign w_n          = (data_size >= 4'd5 && data_size <= MAX_N) ? data_size : MAX_N;
    assign w_word       = r_sr[MAX_DATA-1:0] >> (MAX_N - w_n);

    assign enable_timer  = (r_state == RECEIVING);
    assign rx_data       = r_data;
    assign data_ready    = r_ready;
    assign framing_error = r_ferr;
    assign overrun_error = r_ovr;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      w_next = w_start_edge ? RECEIVING : IDLE;
            RECEIVING: w_next = packet_done ? CHECK : RECEIVING;
            CHECK:     w_next = r_sr[MAX_DATA] ? LOAD : FERR;
            LOAD:      w_next = IDLE;
            FERR:      w_next = r_sync2 ? IDLE : FERR;
            default:   w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
            r_sr    <= '1;
            r_data  <= '0;
            r_ready <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_sync1 <= serial_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            if (w_accept)
                r_sr <= '1;
            else if (r_state == RECEIVING && shift_strobe)
                r_sr <= {r_sync2, r_sr[MAX_DATA:1]};
            if (r_state == LOAD)
                r_data <= w_word;
            // A read coinciding with LOAD neither drops ready nor counts as overrun
            r_ready <= (r_state == LOAD) | (r_ready & ~data_read);
            r_ovr   <= (r_state == LOAD & r_ready & ~data_read) | (r_ovr & ~data_read);
            r_ferr  <= (r_state == FERR) | (r_ferr & ~w_accept);
        end
    end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed plus randomized frames against a frame-level model of the receiver.
module tb_uart_rx_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       serial_in = 1'b1;
    logic [3:0] data_size = 4'd8;
    logic       shift_strobe = 1'b0;
    logic       packet_done = 1'b0;
    logic       data_read = 1'b0;
    logic       enable_timer;
    logic [7:0] rx_data;
    logic       data_ready, framing_error, overrun_error;

    int n_assert = 0;
    int n_fail = 0;

    logic [7:0] exp_data = 8'h00;
    logic       exp_ready = 1'b0, exp_ferr = 1'b0, exp_ovr = 1'b0;

    uart_rx_ctrl #(.MAX_DATA(8)) dut (
        .clk(clk), .rst(rst), .serial_in(serial_in), .data_size(data_size),
        .shift_strobe(shift_strobe), .packet_done(packet_done), .data_read(data_read),
        .enable_timer(enable_timer), .rx_data(rx_data), .data_ready(data_ready),
        .framing_error(framing_error), .overrun_error(overrun_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, ".rx_data"}, 32'(rx_data), 32'(exp_data));
        chk({tag, ".ready"}, 32'(data_ready), 32'(exp_ready));
        chk({tag, ".ferr"}, 32'(framing_error), 32'(exp_ferr));
        chk({tag, ".ovr"}, 32'(overrun_error), 32'(exp_ovr));
    endtask

    task automatic model_reset();
        exp_data = 8'h00;
        exp_ready = 1'b0;
        exp_ferr = 1'b0;
        exp_ovr = 1'b0;
    endtask

    task automatic do_read();
        data_read = 1'b1;
        @(negedge clk);
        data_read = 1'b0;
        exp_ready = 1'b0;
        exp_ovr = 1'b0;
        @(negedge clk);
        chk_outputs("read");
    endtask

    task automatic wait_enable(input string tag);
        for (int k = 0; k < 10 && !enable_timer; k++) @(negedge clk);
        chk({tag, ".enable_on"}, 32'(enable_timer), 32'd1);
    endtask

    // Acts as the bit timer: bit held 8 cycles before each strobe, 16-cycle bit period
    task automatic send_frame(input logic [7:0] d, input logic [3:0] ds, input bit stop, input bit rd_load);
        int n;
        n = (ds >= 5 && ds <= 8) ? int'(ds) : 8;
        data_size = ds;
        serial_in = 1'b1;
        repeat (3) @(negedge clk);
        serial_in = 1'b0;
        wait_enable("frame");
        exp_ferr = 1'b0;
        chk("frame.ferr_cleared", 32'(framing_error), 32'd0);
        for (int b = 0; b <= n; b++) begin
            serial_in = (b == n) ? stop : d[b];
            repeat (8) @(negedge clk);
            shift_strobe = 1'b1;
            packet_done = (b == n);
            @(negedge clk);
            shift_strobe = 1'b0;
            packet_done = 1'b0;
            if (b < n) repeat (7) @(negedge clk);
        end
        chk("frame.enable_off", 32'(enable_timer), 32'd0);
        @(negedge clk);
        data_read = rd_load;
        @(negedge clk);
        data_read = 1'b0;
        if (stop) begin
            exp_ovr = (exp_ready && !rd_load) ? 1'b1 : (rd_load ? 1'b0 : exp_ovr);
            exp_data = d & 8'((9'd1 << n) - 9'd1);
            exp_ready = 1'b1;
        end else begin
            exp_ferr = 1'b1;
            if (rd_load) begin
                exp_ready = 1'b0;
                exp_ovr = 1'b0;
            end
        end
        chk_outputs("frame");
        if (!stop) begin
            repeat (50) @(negedge clk);
            chk("ferr_hold.enable", 32'(enable_timer), 32'd0);
            chk_outputs("ferr_hold");
            serial_in = 1'b1;
            repeat (4) @(negedge clk);
            chk("ferr_exit.enable", 32'(enable_timer), 32'd0);
        end
    endtask

    initial begin
        logic [7:0] d;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk_outputs("reset");
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("idle.enable", 32'(enable_timer), 32'd0);
        end
        chk("idle.ready", 32'(data_ready), 32'd0);

        send_frame(8'hA5, 4'd8, 1'b1, 1'b0);
        chk("a5.data", 32'(rx_data), 32'hA5);
        do_read();
        send_frame(8'h13, 4'd5, 1'b1, 1'b0);
        chk("size5.data", 32'(rx_data), 32'h13);
        do_read();
        send_frame(8'hC7, 4'd3, 1'b1, 1'b0);
        chk("size3.data", 32'(rx_data), 32'hC7);

        send_frame(8'h3C, 4'd8, 1'b0, 1'b0);
        chk("ferr.data_kept", 32'(rx_data), 32'hC7);
        send_frame(8'h66, 4'd8, 1'b1, 1'b0);
        do_read();

        send_frame(8'h11, 4'd8, 1'b1, 1'b0);
        send_frame(8'h22, 4'd8, 1'b1, 1'b0);
        chk("ovr.flag", 32'(overrun_error), 32'd1);
        chk("ovr.data", 32'(rx_data), 32'h22);
        do_read();
        send_frame(8'h11, 4'd8, 1'b1, 1'b0);
        send_frame(8'h22, 4'd8, 1'b1, 1'b1);
        chk("rdload.ready", 32'(data_ready), 32'd1);
        chk("rdload.ovr", 32'(overrun_error), 32'd0);

        data_size = 4'd8;
        serial_in = 1'b0;
        wait_enable("midrst");
        d = 8'h9E;
        for (int b = 0; b < 4; b++) begin
            serial_in = d[b];
            repeat (8) @(negedge clk);
            shift_strobe = 1'b1;
            @(negedge clk);
            shift_strobe = 1'b0;
            repeat (7) @(negedge clk);
        end
        rst = 1'b1;
        serial_in = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk("midrst.enable", 32'(enable_timer), 32'd0);
        chk_outputs("midrst");
        send_frame(8'h5A, 4'd8, 1'b1, 1'b0);
        chk("after_rst.data", 32'(rx_data), 32'h5A);

        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 2) == 0) do_read();
            send_frame(8'($urandom), 4'($urandom_range(0, 15)), ($urandom_range(0, 4) != 0),
                       ($urandom_range(0, 3) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
